// File: rtl/banked_address_decoder.sv
// -----------------------------------------------------------------------------
// banked_address_decoder
//
// Purpose:
//   Registered address decoder for a banked 8-bit system memory map. Each
//   request presented with addr_valid is decoded into one device select plus
//   attribute flags and a translated 17-bit RAM address. The outputs appear
//   one clock later with decode_valid set. Requests can arrive every cycle.
//   An optional expansion control register remaps 8000-FFFF into a second
//   64 KiB of RAM.
//
// Configuration macro:
//   EXPANSION_RAM_EN - when defined, the expansion control register and the
//                      expansion map are built. When undefined, bank_reg reads
//                      as 8'h00, register writes are ignored, and only the
//                      base map is decoded. Latency is the same in both builds.
//
// Ports:
//   clk          in   1          system clock
//   reset        in   1          synchronous, active-high reset
//   addr_valid   in   1          decode request strobe
//   addr         in   ADDR_WIDTH bus address
//   cpu_we       in   1          write qualifier
//   cpu_data     in   8          write data (expansion register)
//   ram_enable   out  1          RAM / ROM select
//   magic_enable out  1          E800-E80F select
//   pia1_enable  out  1          E810-E81F select
//   pia2_enable  out  1          E820-E83F select
//   via_enable   out  1          E840-E87F select
//   crtc_enable  out  1          E880-E8FF select
//   io_enable    out  1          set with any of the four I/O chip selects
//   is_mirrored  out  1          video RAM window 8000-8FFF
//   is_readonly  out  1          access target is read-only
//   ram_addr     out  17         translated RAM address (holds when idle)
//   decode_valid out  1          outputs valid for this cycle
//   bank_reg     out  8          current expansion control register
// -----------------------------------------------------------------------------
module banked_address_decoder #(
    parameter int          ADDR_WIDTH   = 17,
    parameter logic [15:0] EXP_REG_ADDR = 16'hFFF0
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  addr_valid,
    input  logic [ADDR_WIDTH-1:0] addr,
    input  logic                  cpu_we,
    input  logic [7:0]            cpu_data,
    output logic                  ram_enable,
    output logic                  magic_enable,
    output logic                  pia1_enable,
    output logic                  pia2_enable,
    output logic                  via_enable,
    output logic                  crtc_enable,
    output logic                  io_enable,
    output logic                  is_mirrored,
    output logic                  is_readonly,
    output logic [16:0]           ram_addr,
    output logic                  decode_valid,
    output logic [7:0]            bank_reg
);

    logic [15:0] addr16_s;
    logic        upper_nz_s;
    logic [7:0]  bank_s;

    // Next-cycle decode results
    logic        ram_s;
    logic        magic_s;
    logic        pia1_s;
    logic        pia2_s;
    logic        via_s;
    logic        crtc_s;
    logic        io_s;
    logic        mirrored_s;
    logic        readonly_s;
    logic [16:0] ram_addr_s;

    assign addr16_s   = addr[15:0];
    assign upper_nz_s = |addr[ADDR_WIDTH-1:16];

`ifdef EXPANSION_RAM_EN
    logic [7:0] bank_r;
    logic       reg_wr_s;
    logic       peek_s;
    logic       exp_hit_s;

    // Register write: full-width match on the register address only
    assign reg_wr_s = addr_valid & cpu_we & ~upper_nz_s & (addr16_s == EXP_REG_ADDR);

    // Peek-through windows fall back to the base map even in expansion mode
    assign peek_s = (bank_r[6] & (addr16_s >= 16'hE800) & (addr16_s <= 16'hEFFF)) |
                    (bank_r[5] & (addr16_s >= 16'h8000) & (addr16_s <= 16'h8FFF));

    assign exp_hit_s = bank_r[7] & addr16_s[15] & ~peek_s;

    // Expansion control register; reset wins over a simultaneous write
    always_ff @(posedge clk) begin
        if (reset) begin
            bank_r <= 8'h00;
        end else if (reg_wr_s) begin
            bank_r <= cpu_data;
        end else begin
            bank_r <= bank_r;
        end
    end

    assign bank_s = bank_r;
`else
    logic exp_hit_s;
    logic unused_inputs_s;

    assign exp_hit_s       = 1'b0;
    assign bank_s          = 8'h00;
    // Write path is not built in this configuration
    assign unused_inputs_s = &{1'b0, cpu_we, cpu_data};
`endif

    assign bank_reg = bank_s;

    // Combinational decode of the current request (uses pre-write bank_reg)
    always_comb begin
        ram_s      = 1'b0;
        magic_s    = 1'b0;
        pia1_s     = 1'b0;
        pia2_s     = 1'b0;
        via_s      = 1'b0;
        crtc_s     = 1'b0;
        io_s       = 1'b0;
        mirrored_s = 1'b0;
        readonly_s = 1'b0;
        ram_addr_s = {1'b0, addr16_s};

        if (upper_nz_s) begin
            // Anything above 64 KiB reads as ROM image
            ram_s      = 1'b1;
            readonly_s = 1'b1;
        end else if (exp_hit_s) begin
            // Bit 14 chooses the 8000-BFFF or C000-FFFF control pair
            ram_s      = 1'b1;
            ram_addr_s = {1'b1, (addr16_s[14] ? bank_s[3] : bank_s[2]), addr16_s[14:0]};
            readonly_s = addr16_s[14] ? bank_s[1] : bank_s[0];
        end else if (addr16_s <= 16'h7FFF) begin
            ram_s = 1'b1;
        end else if (addr16_s <= 16'h8FFF) begin
            ram_s      = 1'b1;
            mirrored_s = 1'b1;
        end else if ((addr16_s >= 16'hE800) && (addr16_s <= 16'hE80F)) begin
            magic_s = 1'b1;
        end else if ((addr16_s >= 16'hE810) && (addr16_s <= 16'hE81F)) begin
            pia1_s = 1'b1;
            io_s   = 1'b1;
        end else if ((addr16_s >= 16'hE820) && (addr16_s <= 16'hE83F)) begin
            pia2_s = 1'b1;
            io_s   = 1'b1;
        end else if ((addr16_s >= 16'hE840) && (addr16_s <= 16'hE87F)) begin
            via_s = 1'b1;
            io_s  = 1'b1;
        end else if ((addr16_s >= 16'hE880) && (addr16_s <= 16'hE8FF)) begin
            crtc_s = 1'b1;
            io_s   = 1'b1;
        end else begin
            ram_s      = 1'b1;
            readonly_s = 1'b1;
        end
    end

    // Output register stage: one-cycle decode latency, ram_addr holds when idle
    always_ff @(posedge clk) begin
        if (reset) begin
            decode_valid <= 1'b0;
            ram_enable   <= 1'b0;
            magic_enable <= 1'b0;
            pia1_enable  <= 1'b0;
            pia2_enable  <= 1'b0;
            via_enable   <= 1'b0;
            crtc_enable  <= 1'b0;
            io_enable    <= 1'b0;
            is_mirrored  <= 1'b0;
            is_readonly  <= 1'b0;
            ram_addr     <= 17'h00000;
        end else if (addr_valid) begin
            decode_valid <= 1'b1;
            ram_enable   <= ram_s;
            magic_enable <= magic_s;
            pia1_enable  <= pia1_s;
            pia2_enable  <= pia2_s;
            via_enable   <= via_s;
            crtc_enable  <= crtc_s;
            io_enable    <= io_s;
            is_mirrored  <= mirrored_s;
            is_readonly  <= readonly_s;
            ram_addr     <= ram_addr_s;
        end else begin
            decode_valid <= 1'b0;
            ram_enable   <= 1'b0;
            magic_enable <= 1'b0;
            pia1_enable  <= 1'b0;
            pia2_enable  <= 1'b0;
            via_enable   <= 1'b0;
            crtc_enable  <= 1'b0;
            io_enable    <= 1'b0;
            is_mirrored  <= 1'b0;
            is_readonly  <= 1'b0;
            ram_addr     <= ram_addr;
        end
    end

endmodule

// File: doc/banked_address_decoder.md
BANKED_ADDRESS_DECODER -- requirements
Module: banked_address_decoder

Interface
REQ-001 Parameter ADDR_WIDTH, default 17, CPU/bus address width; SHALL be >= 17.
REQ-002 Parameter EXP_REG_ADDR, default 16'hFFF0, 16-bit address of the expansion control register.
REQ-003 Ports SHALL be: clk in 1 system clock; reset in 1 reset; addr_valid in 1 decode request strobe; addr in ADDR_WIDTH bus address; cpu_we in 1 write qualifier; cpu_data in 8 write data.
REQ-004 Outputs SHALL be: ram_enable, magic_enable, pia1_enable, pia2_enable, via_enable, crtc_enable, io_enable, is_mirrored, is_readonly out 1 each (decoded selects); ram_addr out 17 translated RAM address; decode_valid out 1 outputs-valid strobe; bank_reg out 8 current control register.
REQ-005 Design SHALL use one clock, clk; reset SHALL be synchronous and active-high.

Function
REQ-006 Each accepted request (addr_valid=1) SHALL produce registered outputs exactly 1 cycle later, with decode_valid=1 for that cycle; back-to-back requests SHALL be accepted every cycle.
REQ-007 addr_valid=0 SHALL give decode_valid=0 and all select outputs 0 on the next cycle; ram_addr SHALL hold its last value.
REQ-008 If addr[ADDR_WIDTH-1:16] is nonzero, decode SHALL be ROM (ram_enable=1, is_readonly=1), ram_addr={1'b0, addr[15:0]}.
REQ-009 Base map, bank_reg[7]=0: 0000-7FFF RAM; 8000-8FFF RAM+is_mirrored; E800-E80F magic; E810-E81F PIA1+io; E820-E83F PIA2+io; E840-E87F VIA+io; E880-E8FF CRTC+io; all else ROM (ram_enable+is_readonly); ram_addr={1'b0, addr[15:0]}.
REQ-010 Expansion map, bank_reg[7]=1, addresses 8000-FFFF: ram_enable=1, ram_addr={1'b1, sel, addr[14:0]}, where sel=bank_reg[2] for 8000-BFFF and sel=bank_reg[3] for C000-FFFF; is_mirrored=0.
REQ-011 In expansion map, is_readonly SHALL equal bank_reg[0] for 8000-BFFF and bank_reg[1] for C000-FFFF.
REQ-012 Peek-through: bank_reg[6]=1 SHALL decode E800-EFFF per REQ-009; bank_reg[5]=1 SHALL decode 8000-8FFF per REQ-009. Peek-through has priority over REQ-010.
REQ-013 Register write SHALL occur on a request with cpu_we=1 and addr[15:0]=EXP_REG_ADDR and upper bits zero: bank_reg <= cpu_data, regardless of current bank_reg.
REQ-014 A request writing the register SHALL be decoded with the pre-write bank_reg; the new value SHALL apply from the next request.
REQ-015 Register address in expansion mode SHALL still decode per REQ-010 (data also goes to expansion RAM); in base mode, as ROM.
REQ-016 cpu_we=1 to any other address SHALL NOT alter bank_reg.
REQ-017 At most one of the select enables (ram, magic, pia1, pia2, via, crtc) SHALL be 1 in any cycle.
REQ-018 bank_reg output SHALL be the register contents directly (no added latency).

Reset
REQ-019 reset=1 at a clock edge SHALL clear bank_reg to 8'h00, decode_valid and all select outputs to 0, ram_addr to 0.
REQ-020 A request presented while reset=1 SHALL be discarded: no output and no register write.
REQ-021 reset SHALL take priority over simultaneous register write.

Configuration
REQ-022 Macro EXPANSION_RAM_EN: defined, REQ-010 to REQ-016 apply.
REQ-023 Without EXPANSION_RAM_EN: no register storage, bank_reg constant 8'h00, writes to EXP_REG_ADDR ignored, decode is always REQ-008/REQ-009; latency unchanged.

Verification
REQ-024 Reset, then request addr=0x8123 -> next cycle decode_valid=1, ram_enable=1, is_mirrored=1, ram_addr=0x08123.
REQ-025 Requests E810, E830, E850, E8A0, E805 back-to-back -> pia1, pia2, via, crtc, magic each for one cycle; io_enable=1 for first four, 0 for magic.
REQ-026 Write 0x8C to FFF0, then read C123 -> ram_addr=0x1C123, is_readonly=0; the write request itself decodes as ROM.
REQ-027 bank_reg=0xE3, requests 8100, E810, A000 -> VRAM mirrored; PIA1; ram_addr=0x12000 with is_readonly=1.
REQ-028 Write to FFF0 with reset=1 in same cycle -> bank_reg=0x00, decode_valid=0 next cycle.
REQ-029 Macro undefined: write 0x80 to FFF0, then read C000 -> bank_reg=0x00, ROM decode, ram_addr=0x0C000.
